int_sync_crossing_sink_gateway: RTL and testbench

Destination-side stage of the interrupt sync crossing. It receives the registered `auto_in_sync` lines launched by the interrupt sync crossing source and re-synchronizes them into the local clock with a multi-stage synchronizer. Each line then passes through a per-source interrupt gateway that supports level or rising-edge mode. The gateway presents a single interrupt request and a claim/complete handshake to the hart-side interrupt controller.

---
 rtl/int_sync_crossing_sink_gateway.sv | 162 ++++++++++++++++
 tb/tb_int_sync_crossing_sink_gateway.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sync_crossing_sink_gateway.sv
// Interrupt sync-crossing sink: resynchronizes source lines, runs per-source
// level/edge gateways, and exposes irq plus a claim/complete handshake.
//
// Ports:
//   clock, reset_n      - clock, async active-low reset
//   auto_in_sync        - async interrupt lines from the crossing source
//   src_enable/src_edge - per-source enable and edge(1)/level(0) mode
//   irq                 - registered OR of enabled pending sources
//   claim_valid         - claim request; response one cycle later
//   claim_resp_valid    - 1-cycle response strobe
//   claim_id            - granted id (index+1) or 0, held until next response
//   complete_valid/id   - completion of an in-service source
module int_sync_crossing_sink_gateway #(
  parameter int NUM_SRC     = 2,
  parameter int SYNC_STAGES = 3,
  parameter int ID_W        = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] auto_in_sync,
  input  logic [NUM_SRC-1:0] src_enable,
  input  logic [NUM_SRC-1:0] src_edge,
  output logic               irq,
  input  logic               claim_valid,
  output logic               claim_resp_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_SVC
  } gw_state_e;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] chain_q;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] chain_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] prev_d;
  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] trig;
  logic [NUM_SRC-1:0] edge_hit;

  gw_state_e state_q [NUM_SRC];
  gw_state_e state_d [NUM_SRC];
  logic [NUM_SRC-1:0] repend_q;
  logic [NUM_SRC-1:0] repend_d;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] cpl;
  logic [ID_W-1:0]    gid;

  logic            irq_q;
  logic            irq_d;
  logic            resp_q;
  logic            resp_d;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_d;

  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = auto_in_sync;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  assign sync     = chain_q[SYNC_STAGES-1];
  assign prev_d   = sync;
  assign rise     = sync & ~prev_q;
  assign edge_hit = src_edge & rise;
  assign trig     = edge_hit | (~src_edge & sync);

  // Lowest eligible index wins: scan high to low so the last hit sticks.
  always_comb begin
    elig  = '0;
    grant = '0;
    gid   = '0;
    cpl   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = (state_q[i] == ST_PEND) && src_enable[i];
      cpl[i]  = complete_valid && (complete_id == ID_W'(i + 1));
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (claim_valid && elig[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        gid      = ID_W'(i + 1);
      end
    end
  end

  // A rise arriving in the completing cycle is folded into repend so
  // that an edge is never lost across the complete.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      state_d[i]  = state_q[i];
      repend_d[i] = repend_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (trig[i]) state_d[i] = ST_PEND;
        end
        ST_PEND: begin
          if (grant[i]) begin
            state_d[i]  = ST_SVC;
            repend_d[i] = repend_q[i] | edge_hit[i];
          end
        end
        ST_SVC: begin
          if (cpl[i]) begin
            state_d[i]  = (repend_q[i] | edge_hit[i]) ? ST_PEND : ST_IDLE;
            repend_d[i] = 1'b0;
          end else begin
            repend_d[i] = repend_q[i] | edge_hit[i];
          end
        end
        default: begin
          state_d[i]  = ST_IDLE;
          repend_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    irq_d  = |elig;
    resp_d = claim_valid;
    id_d   = claim_valid ? gid : id_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain_q  <= '0;
      prev_q   <= '0;
      repend_q <= '0;
      irq_q    <= 1'b0;
      resp_q   <= 1'b0;
      id_q     <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      chain_q  <= chain_d;
      prev_q   <= prev_d;
      repend_q <= repend_d;
      irq_q    <= irq_d;
      resp_q   <= resp_d;
      id_q     <= id_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign irq              = irq_q;
  assign claim_resp_valid = resp_q;
  assign claim_id         = id_q;

endmodule

// File: tb/tb_int_sync_crossing_sink_gateway.sv
// Self-checking bench for int_sync_crossing_sink_gateway: directed vectors,
// a behavioural reference model, and a per-cycle output compare.
module tb_int_sync_crossing_sink_gateway;

  localparam int NS = 2;
  localparam int S  = 3;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [NS-1:0] auto_in_sync = '0;
  logic [NS-1:0] src_enable = '0;
  logic [NS-1:0] src_edge = '0;
  logic          irq;
  logic          claim_valid = 1'b0;
  logic          claim_resp_valid;
  logic [IW-1:0] claim_id;
  logic          complete_valid = 1'b0;
  logic [IW-1:0] complete_id = '0;

  int checks = 0;
  int failures = 0;
  logic cmp_on = 1'b0;

  int_sync_crossing_sink_gateway #(
    .NUM_SRC(NS),
    .SYNC_STAGES(S),
    .ID_W(IW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .auto_in_sync(auto_in_sync),
    .src_enable(src_enable),
    .src_edge(src_edge),
    .irq(irq),
    .claim_valid(claim_valid),
    .claim_resp_valid(claim_resp_valid),
    .claim_id(claim_id),
    .complete_valid(complete_valid),
    .complete_id(complete_id)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: the line seen by the gateway is the input value
  // captured S edges earlier; prev is the one before that.
  logic [NS-1:0] hist [0:S];
  int            mst [NS];
  logic [NS-1:0] mrep;
  logic          m_irq = 1'b0;
  logic          m_resp = 1'b0;
  logic [IW-1:0] m_id = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= S; k++) hist[k] = '0;
      for (int i = 0; i < NS; i++) mst[i] = 0;
      mrep   = '0;
      m_irq  = 1'b0;
      m_resp = 1'b0;
      m_id   = '0;
    end else begin : upd
      logic [NS-1:0] sy;
      logic [NS-1:0] ri;
      logic          t;
      logic          r;
      int            g;
      sy = hist[S-1];
      ri = sy & ~hist[S];
      g = -1;
      m_irq = 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (mst[i] == 1 && src_enable[i]) begin
          m_irq = 1'b1;
          if (claim_valid && g < 0) g = i;
        end
      end
      for (int i = 0; i < NS; i++) begin
        t = src_edge[i] ? ri[i] : sy[i];
        r = src_edge[i] & ri[i];
        if (mst[i] == 0) begin
          if (t) mst[i] = 1;
        end else if (mst[i] == 1) begin
          if (g == i) begin
            mst[i] = 2;
            if (r) mrep[i] = 1'b1;
          end
        end else begin
          if (r) mrep[i] = 1'b1;
          if (complete_valid && int'(complete_id) == i + 1) begin
            mst[i]  = mrep[i] ? 1 : 0;
            mrep[i] = 1'b0;
          end
        end
      end
      m_resp = claim_valid;
      if (claim_valid) m_id = IW'(g + 1);
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = auto_in_sync;
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("cmp_irq", irq, m_irq);
      chk("cmp_resp", claim_resp_valid, m_resp);
      chk("cmp_id", claim_id, m_id);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic claim_chk(string nm, int exp_id);
    claim_valid = 1'b1;
    cyc(1);
    claim_valid = 1'b0;
    chk({nm, "_v"}, claim_resp_valid, 1);
    chk({nm, "_id"}, claim_id, exp_id);
  endtask

  task automatic complete(int id);
    complete_valid = 1'b1;
    complete_id = IW'(id);
    cyc(1);
    complete_valid = 1'b0;
    complete_id = '0;
  endtask

  initial begin
    src_enable = 2'b11;
    #1 reset_n = 1'b0;
    cyc(2);
    cmp_on = 1'b1;
    chk("rst_irq", irq, 0);
    chk("rst_resp", claim_resp_valid, 0);
    chk("rst_id", claim_id, 0);
    reset_n = 1'b1;

    // Level source 0
    auto_in_sync[0] = 1'b1;
    cyc(4);
    chk("t1_irq_e3", irq, 0);
    cyc(1);
    chk("t1_irq_e4", irq, 1);
    claim_chk("t1_claim", 1);
    cyc(1);
    chk("t1_irq_drop", irq, 0);
    chk("t1_resp_pulse", claim_resp_valid, 0);
    chk("t1_id_hold", claim_id, 1);
    complete(1);
    cyc(1);
    chk("t1_irq_c1", irq, 0);
    cyc(1);
    chk("t1_irq_c2", irq, 1);
    auto_in_sync[0] = 1'b0;
    cyc(5);
    claim_chk("t1_claim2", 1);
    complete(1);
    cyc(3);

    // Edge source 1
    src_edge[1] = 1'b1;
    auto_in_sync[1] = 1'b1;
    cyc(3);
    auto_in_sync[1] = 1'b0;
    cyc(3);
    chk("t2_irq", irq, 1);
    claim_chk("t2_claim", 2);
    for (int p = 0; p < 2; p++) begin
      auto_in_sync[1] = 1'b1;
      cyc(2);
      auto_in_sync[1] = 1'b0;
      cyc(2);
    end
    cyc(3);
    chk("t2_irq_svc", irq, 0);
    complete(2);
    cyc(1);
    chk("t2_irq_repend", irq, 1);
    claim_chk("t2_claim2", 2);
    complete(2);
    cyc(2);
    chk("t2_irq_idle", irq, 0);
    src_edge[1] = 1'b0;

    // Both pending, back-to-back claims
    auto_in_sync = 2'b11;
    cyc(6);
    chk("t3_irq", irq, 1);
    claim_chk("t3_c1", 1);
    claim_chk("t3_c2", 2);
    claim_chk("t3_c3", 0);
    auto_in_sync = 2'b00;
    cyc(5);
    complete(1);
    complete(2);
    cyc(2);
    chk("t3_irq_idle", irq, 0);

    // Enable gating
    src_enable = 2'b10;
    auto_in_sync[0] = 1'b1;
    cyc(6);
    chk("t4_irq_dis", irq, 0);
    claim_chk("t4_c0", 0);
    src_enable = 2'b11;
    cyc(2);
    chk("t4_irq_en", irq, 1);
    claim_chk("t4_c1", 1);
    auto_in_sync[0] = 1'b0;

    // Same-cycle complete and claim; invalid completes
    auto_in_sync[1] = 1'b1;
    cyc(6);
    complete_valid = 1'b1;
    complete_id = 2'd1;
    claim_valid = 1'b1;
    cyc(1);
    complete_valid = 1'b0;
    complete_id = '0;
    claim_valid = 1'b0;
    chk("t5_resp", claim_resp_valid, 1);
    chk("t5_id", claim_id, 2);
    cyc(1);
    chk("t5_irq", irq, 0);
    complete(3);
    complete(0);
    cyc(1);
    claim_chk("t5_none", 0);
    complete(2);
    cyc(2);
    chk("t5_repend", irq, 1);
    claim_chk("t5_c2", 2);
    auto_in_sync[1] = 1'b0;
    cyc(5);
    complete(2);
    cyc(2);

    // Async reset mid-service
    auto_in_sync = 2'b11;
    cyc(6);
    claim_chk("t6_c", 1);
    cyc(1);
    chk("t6_irq_pre", irq, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_irq", irq, 0);
    chk("t6_rst_resp", claim_resp_valid, 0);
    chk("t6_rst_id", claim_id, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(4);
    chk("t6_irq_e3", irq, 0);
    cyc(1);
    chk("t6_irq_e4", irq, 1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
